// File: rtl/instr_fetch_arbiter_if.sv
// Request/response and memory-port signal bundle for instr_fetch_arbiter.
// slave  : arbiter view (takes channel requests and memory data).
// master : environment view (drives channel requests and memory data).
interface instr_fetch_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
);
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH-1:0]        req_txn;
    logic [DATA_W-1:0]        rsp_data;
    logic [NUM_CH-1:0]        rsp_valid;
    logic [ADDR_W-1:0]        m_araddr;
    logic                     m_read_txn;
    logic [DATA_W-1:0]        m_read_data;
    logic                     m_read_valid;

    modport slave (
        input  req_addr, req_txn, m_read_data, m_read_valid,
        output rsp_data, rsp_valid, m_araddr, m_read_txn
    );

    modport master (
        output req_addr, req_txn, m_read_data, m_read_valid,
        input  rsp_data, rsp_valid, m_araddr, m_read_txn
    );
endinterface

// File: rtl/instr_fetch_arbiter.sv
// Round-robin arbiter sharing one single-beat instruction-memory read port
// between NUM_CH fetch sequencers, with duplicate-request and timeout flags.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no read outstanding; grant next pending channel if any
// S_ISSUE | m_read_txn pulse to memory, load timeout counter
// S_WAIT  | waiting for m_read_valid or timeout counter to expire
module instr_fetch_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 128,
    parameter int TMO_CYC = 255
) (
    input  logic                      clk,
    input  logic                      rstn,
    instr_fetch_arbiter_if.slave      bus,
    output logic [$clog2(NUM_CH)-1:0] grant_id,
    output logic                      busy,
    output logic                      drop_err,
    output logic                      tmo_err
);
    localparam int PW = $clog2(NUM_CH);
    // Timer counts down from TMO_CYC-1 to 0, so it needs clog2(TMO_CYC) bits.
    localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [ADDR_W-1:0] addr_q [NUM_CH];
    logic [ADDR_W-1:0] addr_d [NUM_CH];
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     grant_q, grant_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [NUM_CH-1:0] rvalid_q, rvalid_d;
    logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic              drop_q, drop_d;
    logic              tmo_q, tmo_d;

    logic [NUM_CH-1:0] in_service;
    logic [NUM_CH-1:0] dup;
    logic [PW-1:0]     pick;
    logic              pick_vld;
    logic [PW-1:0]     grant_inc;

    assign dup       = bus.req_txn & (pending_q | in_service);
    assign grant_inc = (grant_q == PW'(NUM_CH - 1)) ? '0 : grant_q + PW'(1);

    // Channel currently owning the memory port (none while idle).
    always_comb begin
        in_service = '0;
        if (state_q != S_IDLE) begin
            in_service[grant_q] = 1'b1;
        end
    end

    // First pending channel searching upward from rr_ptr, wrapping mod NUM_CH.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (pending_q[(int'(rr_ptr_q) + k) % NUM_CH]) begin
                pick     = PW'((int'(rr_ptr_q) + k) % NUM_CH);
                pick_vld = 1'b1;
            end
        end
    end

    // Request capture plus next-state and output logic of the arbiter FSM.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        addr_d    = addr_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        araddr_d  = araddr_q;
        rdata_d   = rdata_q;
        rvalid_d  = '0;
        tmo_cnt_d = tmo_cnt_q;
        tmo_d     = 1'b0;
        drop_d    = |dup;

        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.req_txn[i] && !pending_q[i] && !in_service[i]) begin
                pending_d[i] = 1'b1;
                addr_d[i]    = bus.req_addr[i*ADDR_W +: ADDR_W];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    grant_d         = pick;
                    araddr_d        = addr_q[pick];
                    pending_d[pick] = 1'b0;
                    state_d         = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_cnt_d = TW'(TMO_CYC - 1);
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (bus.m_read_valid) begin
                    rdata_d           = bus.m_read_data;
                    rvalid_d[grant_q] = 1'b1;
                    rr_ptr_d          = grant_inc;
                    state_d           = S_IDLE;
                end else if (tmo_cnt_q == '0) begin
                    tmo_d    = 1'b1;
                    rr_ptr_d = grant_inc;
                    state_d  = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared by async reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                addr_q[i] <= '0;
            end
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            araddr_q  <= '0;
            rdata_q   <= '0;
            rvalid_q  <= '0;
            tmo_cnt_q <= '0;
            drop_q    <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            for (int i = 0; i < NUM_CH; i++) begin
                addr_q[i] <= addr_d[i];
            end
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            araddr_q  <= araddr_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            tmo_cnt_q <= tmo_cnt_d;
            drop_q    <= drop_d;
            tmo_q     <= tmo_d;
        end
    end

    assign bus.rsp_data   = rdata_q;
    assign bus.rsp_valid  = rvalid_q;
    assign bus.m_araddr   = araddr_q;
    assign bus.m_read_txn = (state_q == S_ISSUE);
    assign grant_id       = grant_q;
    assign busy           = (state_q != S_IDLE);
    assign drop_err       = drop_q;
    assign tmo_err        = tmo_q;
endmodule

// File: tb/tb_instr_fetch_arbiter.sv
// Directed bench for instr_fetch_arbiter: a per-cycle vector table for the
// single-read and duplicate-request cases, then hand-written sequences for
// contention, timeout and reset in the middle of a read.
module tb_instr_fetch_arbiter;
    localparam int NUM_CH  = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 128;
    localparam int TMO_CYC = 8;

    logic       clk;
    logic       rstn;
    logic [1:0] grant_id;
    logic       busy;
    logic       drop_err;
    logic       tmo_err;

    int total = 0;
    int bad   = 0;

    instr_fetch_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    instr_fetch_arbiter #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TMO_CYC(TMO_CYC)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .bus     (bus_if),
        .grant_id(grant_id),
        .busy    (busy),
        .drop_err(drop_err),
        .tmo_err (tmo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]   txn;
        logic [31:0]  addr;
        logic         mv;
        logic [127:0] md;
        logic         e_txn;
        logic [3:0]   e_rsp;
        logic         e_busy;
        logic [1:0]   e_gid;
        logic [31:0]  e_araddr;
        logic         e_drop;
        logic         e_tmo;
        logic [127:0] e_rdata;
    } vec_t;

    vec_t vecs [14];

    localparam logic [127:0] D1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [127:0] D2 = 128'hdead_beef_cafe_f00d_1357_9bdf_2468_ace0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_txn(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (bus_if.m_read_txn === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk({name, "_txn_seen"}, 128'(ok), 128'd1);
    endtask

    // Wait for the read of channel ch, answer one cycle into WAIT, check
    // the routed response, optionally re-pulse on the rsp_valid cycle.
    task automatic serve(input string name, input int ch, input logic [31:0] addr,
                         input logic [127:0] data, input logic [3:0] repulse);
        wait_txn(name);
        chk({name, "_grant"}, 128'(grant_id), 128'(ch));
        chk({name, "_araddr"}, 128'(bus_if.m_araddr), 128'(addr));
        step();
        bus_if.m_read_valid = 1'b1;
        bus_if.m_read_data  = data;
        step();
        bus_if.m_read_valid = 1'b0;
        bus_if.m_read_data  = '0;
        chk({name, "_rsp_valid"}, 128'(bus_if.rsp_valid), 128'(4'b0001 << ch));
        chk({name, "_rsp_data"}, bus_if.rsp_data, data);
        bus_if.req_txn = repulse;
        step();
        bus_if.req_txn = '0;
        chk({name, "_rsp_valid_clr"}, 128'(bus_if.rsp_valid), 128'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"}, 128'(busy), 128'd0);
        chk({name, "_rsp_valid"}, 128'(bus_if.rsp_valid), 128'd0);
        chk({name, "_m_read_txn"}, 128'(bus_if.m_read_txn), 128'd0);
        chk({name, "_grant"}, 128'(grant_id), 128'd0);
        chk({name, "_araddr"}, 128'(bus_if.m_araddr), 128'd0);
        chk({name, "_drop"}, 128'(drop_err), 128'd0);
        chk({name, "_tmo"}, 128'(tmo_err), 128'd0);
        chk({name, "_rsp_data"}, bus_if.rsp_data, 128'd0);
    endtask

    initial begin
        logic [127:0] last_data;

        //           txn     addr   mv  md  | txn rsp     bsy gid  araddr  drp tmo rdata
        vecs[0]  = '{4'b0100, 32'h40, 0, 0,  0, 4'b0000, 0, 2'd0, 32'h00, 0, 0, 128'd0};
        vecs[1]  = '{4'b0000, 32'h00, 0, 0,  1, 4'b0000, 1, 2'd2, 32'h40, 0, 0, 128'd0};
        vecs[2]  = '{4'b0000, 32'h00, 0, 0,  0, 4'b0000, 1, 2'd2, 32'h40, 0, 0, 128'd0};
        vecs[3]  = '{4'b0000, 32'h00, 0, 0,  0, 4'b0000, 1, 2'd2, 32'h40, 0, 0, 128'd0};
        vecs[4]  = '{4'b0000, 32'h00, 0, 0,  0, 4'b0000, 1, 2'd2, 32'h40, 0, 0, 128'd0};
        vecs[5]  = '{4'b0000, 32'h00, 1, D1, 0, 4'b0100, 0, 2'd2, 32'h40, 0, 0, D1};
        vecs[6]  = '{4'b0000, 32'h00, 0, 0,  0, 4'b0000, 0, 2'd2, 32'h40, 0, 0, D1};
        vecs[7]  = '{4'b0010, 32'h10, 0, 0,  0, 4'b0000, 0, 2'd2, 32'h40, 0, 0, D1};
        vecs[8]  = '{4'b0010, 32'h20, 0, 0,  1, 4'b0000, 1, 2'd1, 32'h10, 1, 0, D1};
        vecs[9]  = '{4'b0000, 32'h00, 0, 0,  0, 4'b0000, 1, 2'd1, 32'h10, 0, 0, D1};
        vecs[10] = '{4'b0000, 32'h00, 0, 0,  0, 4'b0000, 1, 2'd1, 32'h10, 0, 0, D1};
        vecs[11] = '{4'b0000, 32'h00, 1, D2, 0, 4'b0010, 0, 2'd1, 32'h10, 0, 0, D2};
        vecs[12] = '{4'b0000, 32'h00, 0, 0,  0, 4'b0000, 0, 2'd1, 32'h10, 0, 0, D2};
        vecs[13] = '{4'b0000, 32'h00, 1, D1, 0, 4'b0000, 0, 2'd1, 32'h10, 0, 0, D2};

        rstn                = 1'b0;
        bus_if.req_addr     = '0;
        bus_if.req_txn      = '0;
        bus_if.m_read_valid = 1'b0;
        bus_if.m_read_data  = '0;
        #12;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Single read and duplicate request, cycle by cycle.
        for (int i = 0; i < 14; i++) begin
            bus_if.req_txn      = vecs[i].txn;
            bus_if.req_addr     = {4{vecs[i].addr}};
            bus_if.m_read_valid = vecs[i].mv;
            bus_if.m_read_data  = vecs[i].md;
            step();
            chk($sformatf("v%0d_m_read_txn", i), 128'(bus_if.m_read_txn), 128'(vecs[i].e_txn));
            chk($sformatf("v%0d_rsp_valid", i), 128'(bus_if.rsp_valid), 128'(vecs[i].e_rsp));
            chk($sformatf("v%0d_busy", i), 128'(busy), 128'(vecs[i].e_busy));
            chk($sformatf("v%0d_grant", i), 128'(grant_id), 128'(vecs[i].e_gid));
            chk($sformatf("v%0d_araddr", i), 128'(bus_if.m_araddr), 128'(vecs[i].e_araddr));
            chk($sformatf("v%0d_drop", i), 128'(drop_err), 128'(vecs[i].e_drop));
            chk($sformatf("v%0d_tmo", i), 128'(tmo_err), 128'(vecs[i].e_tmo));
            chk($sformatf("v%0d_rsp_data", i), bus_if.rsp_data, vecs[i].e_rdata);
        end
        bus_if.req_txn      = '0;
        bus_if.m_read_valid = 1'b0;
        bus_if.m_read_data  = '0;

        // Contention: reset puts rr_ptr back to 0.
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();
        bus_if.req_addr = {32'h130, 32'h120, 32'h110, 32'h100};
        bus_if.req_txn  = 4'hF;
        step();
        bus_if.req_txn  = '0;
        for (int c = 0; c < 4; c++) begin
            serve($sformatf("rr1_c%0d", c), c, 32'h100 + 32'(c) * 32'h10,
                  {4{32'hC0DE_0000 + 32'(c)}}, 4'b0000);
        end

        // Second all-request round starts at ch0; ch0 re-requests on its
        // rsp_valid cycle and is served again after ch3.
        bus_if.req_addr = {32'h230, 32'h220, 32'h210, 32'h200};
        bus_if.req_txn  = 4'hF;
        step();
        bus_if.req_txn  = '0;
        bus_if.req_addr = {32'h230, 32'h220, 32'h210, 32'h2F0};
        serve("rr2_c0", 0, 32'h200, {4{32'hBEEF_0000}}, 4'b0001);
        serve("rr2_c1", 1, 32'h210, {4{32'hBEEF_0001}}, 4'b0000);
        serve("rr2_c2", 2, 32'h220, {4{32'hBEEF_0002}}, 4'b0000);
        serve("rr2_c3", 3, 32'h230, {4{32'hBEEF_0003}}, 4'b0000);
        serve("rr2_c0b", 0, 32'h2F0, {4{32'hBEEF_00F0}}, 4'b0000);
        last_data = {4{32'hBEEF_00F0}};

        // Timeout with silent memory.
        bus_if.req_addr = {32'h300, 32'h0, 32'h0, 32'h0};
        bus_if.req_txn  = 4'b1000;
        step();
        bus_if.req_txn  = '0;
        wait_txn("tmo");
        chk("tmo_grant", 128'(grant_id), 128'd3);
        for (int n = 1; n <= TMO_CYC; n++) begin
            step();
            chk($sformatf("tmo_w%0d_tmo", n), 128'(tmo_err), 128'd0);
            chk($sformatf("tmo_w%0d_busy", n), 128'(busy), 128'd1);
        end
        step();
        chk("tmo_pulse", 128'(tmo_err), 128'd1);
        chk("tmo_busy_after", 128'(busy), 128'd0);
        chk("tmo_no_rsp", 128'(bus_if.rsp_valid), 128'd0);
        step();
        chk("tmo_pulse_clr", 128'(tmo_err), 128'd0);
        bus_if.m_read_valid = 1'b1;
        bus_if.m_read_data  = D1;
        step();
        bus_if.m_read_valid = 1'b0;
        bus_if.m_read_data  = '0;
        step();
        chk("late_valid_rsp", 128'(bus_if.rsp_valid), 128'd0);
        chk("late_valid_busy", 128'(busy), 128'd0);
        chk("late_valid_data", bus_if.rsp_data, last_data);
        bus_if.req_addr = {32'h0, 32'h0, 32'h1111_0000, 32'h0};
        bus_if.req_txn  = 4'b0010;
        step();
        bus_if.req_txn  = '0;
        serve("post_tmo", 1, 32'h1111_0000, D2, 4'b0000);

        // Reset while a read is outstanding and another channel is pending.
        bus_if.req_addr = {32'h0, 32'h2220, 32'h0, 32'hABC0};
        bus_if.req_txn  = 4'b0001;
        step();
        bus_if.req_txn  = '0;
        wait_txn("rst_mid");
        step();
        bus_if.req_txn  = 4'b0100;
        step();
        bus_if.req_txn  = '0;
        chk("rst_mid_busy_before", 128'(busy), 128'd1);
        #2;
        rstn = 1'b0;
        #2;
        chk_all_zero("rst_mid");
        step();
        rstn = 1'b1;
        step();
        step();
        step();
        chk("rst_pending_clr_busy", 128'(busy), 128'd0);
        chk("rst_pending_clr_txn", 128'(bus_if.m_read_txn), 128'd0);
        bus_if.req_txn = 4'b0100;
        step();
        bus_if.req_txn = '0;
        serve("post_rst", 2, 32'h2220, D1, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
